// File: rtl/ddr3_read_sequencer.sv
// ddr3_read_sequencer: issues a bounded stream of DDR3 read commands and tracks their returns
module ddr3_read_sequencer #(
    parameter int ADDR_STEP = 8,
    parameter int MAX_OUT   = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_cmds,
    input  logic             out_afull,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       m_cmd,
    output logic [31:0]      m_addr,
    output logic             m_en,
    input  logic             m_rdy,
    output logic [287:0]     m_wdf_data,
    output logic [35:0]      m_wdf_mask,
    output logic             m_wdf_end,
    output logic             m_wdf_wren,
    input  logic [287:0]     m_rd_data,
    input  logic             m_rd_data_valid,
    input  logic             m_rd_data_end,
    output logic [287:0]     d_out,
    output logic             d_valid,
    output logic             d_end,
    output logic [CNT_W-1:0] beats
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] num, num_nx, issued, issued_nx, beats_nx;
    logic [3:0]       outstanding, outstanding_nx;
    logic [31:0]      addr_nx;
    logic             en_nx, err_nx, abort_seen, abort_seen_nx;
    logic             hs, ret;

    assign hs         = m_en & m_rdy;
    assign ret        = m_rd_data_valid & m_rd_data_end;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign m_cmd      = 3'b001;
    assign m_wdf_data = '0;
    assign m_wdf_mask = '1;
    assign m_wdf_end  = 1'b0;
    assign m_wdf_wren = 1'b0;

    // next-state, command issue and outstanding-read bookkeeping
    always_comb begin
        state_nx       = state;
        num_nx         = num;
        issued_nx      = issued;
        addr_nx        = m_addr;
        en_nx          = m_en;
        err_nx         = err;
        abort_seen_nx  = abort_seen;
        outstanding_nx = outstanding;
        beats_nx       = d_valid ? beats + 1'b1 : beats;
        if (hs && !ret)
            outstanding_nx = outstanding + 4'd1;
        else if (!hs && ret) begin
            if (outstanding == 4'd0)
                err_nx = 1'b1;
            else
                outstanding_nx = outstanding - 4'd1;
        end
        case (state)
            IDLE: begin
                if (start) begin
                    err_nx   = 1'b0;
                    beats_nx = '0;
                    if (num_cmds != '0) begin
                        state_nx      = ISSUE;
                        num_nx        = num_cmds;
                        issued_nx     = '0;
                        addr_nx       = base_addr;
                        abort_seen_nx = 1'b0;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            ISSUE: begin
                if (m_en) begin
                    // a pending command is never withdrawn; an abort is remembered until it completes
                    if (abort)
                        abort_seen_nx = 1'b1;
                    if (hs) begin
                        issued_nx = issued + 1'b1;
                        addr_nx   = m_addr + 32'(ADDR_STEP);
                        en_nx     = (issued_nx < num) && (outstanding_nx < 4'(MAX_OUT)) &&
                                    !out_afull && !abort && !abort_seen;
                        if (issued_nx == num || abort || abort_seen)
                            state_nx = DRAIN;
                    end
                end else if (abort) begin
                    state_nx = DRAIN;
                end else begin
                    en_nx = (issued < num) && (outstanding < 4'(MAX_OUT)) && !out_afull;
                end
            end
            DRAIN: begin
                if (outstanding == 4'd0)
                    state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // state and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num         <= '0;
            issued      <= '0;
            m_addr      <= '0;
            m_en        <= 1'b0;
            err         <= 1'b0;
            abort_seen  <= 1'b0;
            outstanding <= '0;
            beats       <= '0;
        end else begin
            state       <= state_nx;
            num         <= num_nx;
            issued      <= issued_nx;
            m_addr      <= addr_nx;
            m_en        <= en_nx;
            err         <= err_nx;
            abort_seen  <= abort_seen_nx;
            outstanding <= outstanding_nx;
            beats       <= beats_nx;
        end
    end

    // one-cycle registered copy of the read return path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= '0;
            d_valid <= 1'b0;
            d_end   <= 1'b0;
        end else begin
            d_out   <= m_rd_data;
            d_valid <= m_rd_data_valid;
            d_end   <= m_rd_data_end;
        end
    end
endmodule

// File: tb/tb_ddr3_read_sequencer.sv
// tb_ddr3_read_sequencer: directed and randomized checks of the read sequencer against a behavioural model
module tb_ddr3_read_sequencer;
    localparam int STEP = 8;
    localparam int MAXO = 4;
    localparam int BIG  = 1000000;

    logic         clk = 0, rst_n = 1, start = 0, abort = 0, out_afull = 0, m_rdy = 0;
    logic [31:0]  base_addr = '0;
    logic [15:0]  num_cmds = '0;
    logic [287:0] m_rd_data = '0;
    logic         m_rd_data_valid = 0, m_rd_data_end = 0;
    logic         busy, done, err, m_en, m_wdf_end, m_wdf_wren, d_valid, d_end;
    logic [2:0]   m_cmd;
    logic [31:0]  m_addr;
    logic [287:0] m_wdf_data, d_out;
    logic [35:0]  m_wdf_mask;
    logic [15:0]  beats;

    int          checks = 0, errors = 0;
    int          n_hs, n_done, m_num, m_out, ret_budget, bpc, rdy_pct, afull_pct, abort_pct, ret_pct;
    logic [31:0] m_base;
    logic [15:0] m_beats;
    bit          m_err, m_dv, abort_pend, rand_mode;
    bit          start_ok = 1;
    bit          ret_q[$];

    ddr3_read_sequencer #(.ADDR_STEP(STEP), .MAX_OUT(MAXO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .num_cmds(num_cmds), .out_afull(out_afull), .busy(busy), .done(done), .err(err),
        .m_cmd(m_cmd), .m_addr(m_addr), .m_en(m_en), .m_rdy(m_rdy), .m_wdf_data(m_wdf_data),
        .m_wdf_mask(m_wdf_mask), .m_wdf_end(m_wdf_end), .m_wdf_wren(m_wdf_wren),
        .m_rd_data(m_rd_data), .m_rd_data_valid(m_rd_data_valid), .m_rd_data_end(m_rd_data_end),
        .d_out(d_out), .d_valid(d_valid), .d_end(d_end), .beats(beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs, advance, update the model, compare
    task automatic cyc();
        logic         pe_en, pe_rdy, pe_v, pe_e, pe_afull, pe_abort, pe_start, hs, ret, ok;
        logic [31:0]  pe_addr, pe_base;
        logic [15:0]  pe_num;
        logic [287:0] pe_d;
        int           out_pre, hs_pre;
        if (rand_mode) begin
            m_rdy     = $urandom_range(99) < rdy_pct;
            out_afull = $urandom_range(99) < afull_pct;
            abort     = $urandom_range(99) < abort_pct;
        end
        for (int i = 0; i < 9; i++) m_rd_data[i*32 +: 32] = $urandom();
        if (ret_q.size() > 0 && ret_budget > 0 && $urandom_range(99) < ret_pct) begin
            m_rd_data_valid = 1;
            m_rd_data_end   = ret_q.pop_front();
            if (m_rd_data_end) ret_budget--;
        end else begin
            m_rd_data_valid = 0;
            m_rd_data_end   = 0;
        end
        pe_en = m_en; pe_rdy = m_rdy; pe_addr = m_addr; pe_v = m_rd_data_valid; pe_e = m_rd_data_end;
        pe_d = m_rd_data; pe_afull = out_afull; pe_abort = abort; pe_start = start;
        pe_num = num_cmds; pe_base = base_addr;
        out_pre = m_out; hs_pre = n_hs;
        @(posedge clk);
        #1;
        hs  = pe_en & pe_rdy;
        ret = pe_v & pe_e;
        if (hs) begin
            chk("cmd_addr", pe_addr, m_base + 32'(STEP * n_hs));
            n_hs++;
            for (int b = 1; b <= bpc; b++) ret_q.push_back(b == bpc);
        end
        if (hs && !ret) m_out++;
        else if (!hs && ret) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end
        m_beats = m_beats + 16'(m_dv);
        m_dv    = pe_v;
        if (pe_en && pe_abort) abort_pend = 1;
        if (pe_start && start_ok) begin
            m_err = 0; m_beats = 0; n_hs = 0; m_num = int'(pe_num); m_base = pe_base; abort_pend = 0;
        end
        if (done) n_done++;
        chk("d_valid", d_valid, pe_v);
        chk("d_end", d_end, pe_e);
        chk("d_out", d_out, pe_d);
        chk("err", err, m_err);
        chk("beats", beats, m_beats);
        if (pe_en && !pe_rdy) begin
            chk("hold_en", m_en, 1);
            chk("hold_addr", m_addr, pe_addr);
        end else if (m_en) begin
            ok = (pe_en ? (n_hs < m_num && m_out < MAXO) : (hs_pre < m_num && out_pre < MAXO)) &&
                 !pe_afull && !pe_abort && !abort_pend;
            chk("en_cond", ok, 1);
        end
    endtask

    task automatic go(input logic [31:0] b, input int n);
        base_addr = b;
        num_cmds  = 16'(n);
        start     = 1;
        n_done    = 0;
        cyc();
        start = 0;
    endtask

    task automatic run_idle(input int max);
        int k = 0;
        while (!(n_done > 0 && !busy) && k < max) begin
            cyc();
            k++;
        end
        chk("seq_timeout", k < max, 1);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        chk("rst_m_en", m_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_end", d_end, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_beats", beats, 0);
        m_out = 0; m_err = 0; m_beats = 0; m_dv = 0; abort_pend = 0;
        start = 0; abort = 0; m_rdy = 0; out_afull = 0; m_rd_data_valid = 0; m_rd_data_end = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        do_reset();
        chk("m_cmd", m_cmd, 3'b001);
        chk("wdf_data", m_wdf_data, 288'd0);
        chk("wdf_mask", m_wdf_mask, {36{1'b1}});
        chk("wdf_end_wren", {m_wdf_end, m_wdf_wren}, 2'b00);

        // basic three-command sequence with two-beat returns and an ignored mid-run start
        bpc = 2; ret_pct = 100; ret_budget = BIG; m_rdy = 1;
        go(32'h100, 3);
        cyc();
        start_ok = 0; base_addr = 32'hdead0000; num_cmds = 99; start = 1;
        cyc();
        start = 0; start_ok = 1;
        run_idle(100);
        chk("s1_hs", n_hs, 3);
        chk("s1_beats", beats, 6);
        chk("s1_done", n_done, 1);
        chk("s1_busy", busy, 0);

        // outstanding cap with returns released one at a time
        bpc = 1; ret_budget = 0;
        go(32'h1000, 10);
        repeat (12) cyc();
        chk("s2_cap", n_hs, 4);
        chk("s2_en_low", m_en, 0);
        for (int i = 0; i < 6; i++) begin
            ret_budget = 1;
            repeat (5) cyc();
            chk("s2_step", n_hs, 5 + i);
        end
        ret_budget = BIG;
        run_idle(100);
        chk("s2_done", n_done, 1);

        // pending command held through m_rdy low and out_afull
        m_rdy = 0;
        go(32'h2000, 4);
        k = 0;
        while (!m_en && k < 10) begin cyc(); k++; end
        chk("s3_rise", m_en, 1);
        out_afull = 1;
        repeat (5) cyc();
        chk("s3_addr", m_addr, 32'h2000);
        chk("s3_en", m_en, 1);
        m_rdy = 1; out_afull = 0;
        run_idle(100);
        chk("s3_hs", n_hs, 4);

        // abort with m_en low after two commands
        ret_budget = 0; m_rdy = 1;
        go(32'h3000, 8);
        k = 0;
        while (n_hs < 1 && k < 20) begin cyc(); k++; end
        out_afull = 1;
        k = 0;
        while (n_hs < 2 && k < 20) begin cyc(); k++; end
        chk("s4_two", n_hs, 2);
        chk("s4_en_low", m_en, 0);
        abort = 1;
        cyc();
        abort = 0; out_afull = 0;
        repeat (10) cyc();
        chk("s4_noissue", n_hs, 2);
        chk("s4_wait", n_done, 0);
        ret_budget = 1;
        repeat (5) cyc();
        chk("s4_wait1", n_done, 0);
        chk("s4_busy", busy, 1);
        ret_budget = 1;
        run_idle(20);
        chk("s4_hs", n_hs, 2);
        chk("s4_done", n_done, 1);

        // abort while a command is pending: it still completes, nothing follows
        m_rdy = 0; ret_budget = BIG;
        go(32'h3800, 8);
        k = 0;
        while (!m_en && k < 10) begin cyc(); k++; end
        abort = 1;
        cyc();
        abort = 0;
        repeat (3) cyc();
        chk("s4b_hold", m_en, 1);
        m_rdy = 1;
        run_idle(50);
        chk("s4b_hs", n_hs, 1);

        // zero-length sequence, stray end-beat in IDLE, err cleared by next start
        go(32'h5000, 0);
        run_idle(6);
        chk("s5_hs", n_hs, 0);
        chk("s5_done", n_done, 1);
        chk("s5_busy", busy, 0);
        repeat (2) cyc();
        ret_q.push_back(1);
        ret_budget = 1;
        repeat (3) cyc();
        chk("s5_err", err, 1);
        repeat (3) cyc();
        chk("s5_sticky", err, 1);
        ret_budget = BIG;
        go(32'h5100, 1);
        chk("s5_clr", err, 0);
        run_idle(30);
        chk("s5b_hs", n_hs, 1);

        // reset with three reads in flight; their late returns raise err
        ret_budget = 0; m_rdy = 1;
        go(32'h6000, 8);
        k = 0;
        while (n_hs < 3 && k < 20) begin cyc(); k++; end
        chk("s6_three", n_hs, 3);
        do_reset();
        ret_budget = 3;
        repeat (8) cyc();
        chk("s6_err", err, 1);
        chk("s6_busy", busy, 0);
        chk("s6_q", ret_q.size(), 0);

        // randomized sequences
        rand_mode = 1; ret_budget = BIG;
        for (int s = 0; s < 20; s++) begin
            rdy_pct   = $urandom_range(40, 100);
            afull_pct = $urandom_range(0, 30);
            abort_pct = (s % 3 == 0) ? 4 : 0;
            ret_pct   = $urandom_range(30, 100);
            bpc       = $urandom_range(1, 3);
            n         = $urandom_range(1, 12);
            go((s == 0) ? 32'hFFFF_FFF0 : $urandom(), n);
            run_idle(3000);
            chk("rnd_done", n_done, 1);
            chk("rnd_busy", busy, 0);
            chk("rnd_drained", ret_q.size(), 0);
            chk("rnd_le", n_hs <= n, 1);
            if (abort_pct == 0) chk("rnd_hs", n_hs, n);
        end
        rand_mode = 0; abort = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
